// File: rtl/ft_recovery_sequencer.sv
// Lockstep checker and rollback sequencer for the dual zeroriscy core: compares
// both regfile write ports every cycle, keeps a shadow GPR file plus the last
// agreed PC, and on disagreement halts both cores and rewrites their state.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   we/waddr/wdata_{a,b}_i, pc_i   regfile write ports of both cores, core 0 PC
//   halted_{a,b}_i, gnt_{a,b}_i    debug_halted / debug_gnt from each core
//   halt_o, resume_o               debug halt request, one-cycle resume pulse
//   dbg_req/we/addr/wdata_o        shared debug write port to both cores
//   busy_o, err_count_o            not-IDLE flag, saturating mismatch count
// All outputs are registered: they are computed from the next state and loaded
// on the same edge that loads the state register.
module ft_recovery_sequencer #(
  parameter logic [14:0] DBG_GPR_BASE = 15'h400,
  parameter logic [14:0] DBG_NPC_ADDR = 15'h2000,
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_a_i,
  input  logic                 we_b_i,
  input  logic [4:0]           waddr_a_i,
  input  logic [4:0]           waddr_b_i,
  input  logic [31:0]          wdata_a_i,
  input  logic [31:0]          wdata_b_i,
  input  logic [31:0]          pc_i,
  input  logic                 halted_a_i,
  input  logic                 halted_b_i,
  input  logic                 gnt_a_i,
  input  logic                 gnt_b_i,
  output logic                 halt_o,
  output logic                 resume_o,
  output logic                 dbg_req_o,
  output logic                 dbg_we_o,
  output logic [14:0]          dbg_addr_o,
  output logic [31:0]          dbg_wdata_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_WR_REG,
    S_WR_PC,
    S_RESUME
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [4:0]           r_idx, w_idx_nxt;
  logic                 r_ga, r_gb, w_ga_nxt, w_gb_nxt;
  logic [CNT_WIDTH-1:0] r_err_cnt, w_err_nxt;
  logic [31:0]          r_shadow [32];
  logic [31:0]          r_spc;

  logic                 r_halt, r_resume, r_dbg_req, r_dbg_we, r_busy;
  logic [14:0]          r_dbg_addr;
  logic [31:0]          r_dbg_wdata;

  logic                 w_halt_nxt, w_resume_nxt, w_req_nxt, w_busy_nxt;
  logic [14:0]          w_addr_nxt;
  logic [31:0]          w_wdata_nxt;

  logic                 w_mismatch, w_agree;
  logic                 w_ga_seen, w_gb_seen, w_xfer_done;

  assign w_mismatch = (we_a_i != we_b_i) ||
                      (we_a_i && we_b_i &&
                       ((waddr_a_i != waddr_b_i) || (wdata_a_i != wdata_b_i)));
  assign w_agree    = we_a_i && we_b_i &&
                      (waddr_a_i == waddr_b_i) && (wdata_a_i == wdata_b_i);

  // A transfer completes on the cycle where both grants have been seen,
  // counting a grant arriving this very cycle; grants only count while the
  // request is actually on the bus.
  assign w_ga_seen   = r_ga || gnt_a_i;
  assign w_gb_seen   = r_gb || gnt_b_i;
  assign w_xfer_done = r_dbg_req && w_ga_seen && w_gb_seen;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ga_nxt    = r_ga;
    w_gb_nxt    = r_gb;
    w_err_nxt   = r_err_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_mismatch) begin
          w_state_nxt = S_HALT;
          if (r_err_cnt != {CNT_WIDTH{1'b1}}) begin
            w_err_nxt = r_err_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      S_HALT: begin
        if (halted_a_i && halted_b_i) begin
          w_state_nxt = S_WR_REG;
          w_idx_nxt   = 5'd1;
          w_ga_nxt    = 1'b0;
          w_gb_nxt    = 1'b0;
        end
      end
      S_WR_REG: begin
        if (w_xfer_done) begin
          w_ga_nxt = 1'b0;
          w_gb_nxt = 1'b0;
          if (r_idx == 5'd31) begin
            w_state_nxt = S_WR_PC;
            w_idx_nxt   = 5'd0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end else begin
          w_ga_nxt = w_ga_seen;
          w_gb_nxt = w_gb_seen;
        end
      end
      S_WR_PC: begin
        if (w_xfer_done) begin
          w_state_nxt = S_RESUME;
          w_ga_nxt    = 1'b0;
          w_gb_nxt    = 1'b0;
        end else begin
          w_ga_nxt = w_ga_seen;
          w_gb_nxt = w_gb_seen;
        end
      end
      S_RESUME: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Output values for the state being entered; the shadow file is frozen
    // outside IDLE, so reading it here is stable for the whole transfer.
    w_halt_nxt   = (w_state_nxt == S_HALT) || (w_state_nxt == S_WR_REG) ||
                   (w_state_nxt == S_WR_PC);
    w_req_nxt    = (w_state_nxt == S_WR_REG) || (w_state_nxt == S_WR_PC);
    w_resume_nxt = (w_state_nxt == S_RESUME);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_addr_nxt   = 15'h0;
    w_wdata_nxt  = 32'h0;
    if (w_state_nxt == S_WR_REG) begin
      w_addr_nxt  = DBG_GPR_BASE + {8'h00, w_idx_nxt, 2'b00};
      w_wdata_nxt = r_shadow[w_idx_nxt];
    end else if (w_state_nxt == S_WR_PC) begin
      w_addr_nxt  = DBG_NPC_ADDR;
      w_wdata_nxt = r_spc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_ga        <= 1'b0;
      r_gb        <= 1'b0;
      r_err_cnt   <= '0;
      r_halt      <= 1'b0;
      r_resume    <= 1'b0;
      r_dbg_req   <= 1'b0;
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= 15'h0;
      r_dbg_wdata <= 32'h0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_ga        <= w_ga_nxt;
      r_gb        <= w_gb_nxt;
      r_err_cnt   <= w_err_nxt;
      r_halt      <= w_halt_nxt;
      r_resume    <= w_resume_nxt;
      r_dbg_req   <= w_req_nxt;
      r_dbg_we    <= w_req_nxt;
      r_dbg_addr  <= w_addr_nxt;
      r_dbg_wdata <= w_wdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Shadow state captures only writes both cores agree on. Entry 0 is never
  // written, so x0 always reads back as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        r_shadow[i] <= 32'h0;
      end
      r_spc <= BOOT_ADDR;
    end else if ((r_state == S_IDLE) && w_agree) begin
      if (waddr_a_i != 5'd0) begin
        r_shadow[waddr_a_i] <= wdata_a_i;
      end
      r_spc <= pc_i;
    end
  end

  assign halt_o      = r_halt;
  assign resume_o    = r_resume;
  assign dbg_req_o   = r_dbg_req;
  assign dbg_we_o    = r_dbg_we;
  assign dbg_addr_o  = r_dbg_addr;
  assign dbg_wdata_o = r_dbg_wdata;
  assign busy_o      = r_busy;
  assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_ft_recovery_sequencer.sv
// Bench for ft_recovery_sequencer: a transaction-level model (shadow array,
// saved PC, queue of pending debug writes) checked every cycle, plus directed
// literal checks on the recovery write log.
module tb_ft_recovery_sequencer;

  localparam logic [14:0] GPR_BASE = 15'h400;
  localparam logic [14:0] NPC_ADDR = 15'h2000;
  localparam logic [31:0] BOOT     = 32'h0000_0080;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        we_a_i = 1'b0, we_b_i = 1'b0;
  logic [4:0]  waddr_a_i = 5'd0, waddr_b_i = 5'd0;
  logic [31:0] wdata_a_i = 32'h0, wdata_b_i = 32'h0, pc_i = 32'h0;
  logic        halted_a_i = 1'b0, halted_b_i = 1'b0;
  logic        gnt_a_i = 1'b0, gnt_b_i = 1'b0;
  logic        halt_o, resume_o, dbg_req_o, dbg_we_o, busy_o;
  logic [14:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic [7:0]  err_count_o;

  always #5 clk_i = ~clk_i;

  ft_recovery_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .we_a_i(we_a_i), .we_b_i(we_b_i),
    .waddr_a_i(waddr_a_i), .waddr_b_i(waddr_b_i),
    .wdata_a_i(wdata_a_i), .wdata_b_i(wdata_b_i),
    .pc_i(pc_i),
    .halted_a_i(halted_a_i), .halted_b_i(halted_b_i),
    .gnt_a_i(gnt_a_i), .gnt_b_i(gnt_b_i),
    .halt_o(halt_o), .resume_o(resume_o),
    .dbg_req_o(dbg_req_o), .dbg_we_o(dbg_we_o),
    .dbg_addr_o(dbg_addr_o), .dbg_wdata_o(dbg_wdata_o),
    .busy_o(busy_o), .err_count_o(err_count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [14:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       m_q[$];
  logic [31:0] m_sh [32];
  logic [31:0] m_spc = BOOT;
  int          m_mode = 0;  // 0 idle, 1 awaiting halt, 2 transferring, 3 resume
  int          m_err = 0;
  bit          m_ga = 0, m_gb = 0;

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    if (!rst_ni) begin
      foreach (m_sh[i]) m_sh[i] = 32'h0;
      m_spc = BOOT; m_mode = 0; m_err = 0; m_ga = 0; m_gb = 0;
      m_q.delete();
    end else begin
      case (m_mode)
        0: begin
          if ((we_a_i != we_b_i) ||
              (we_a_i && (waddr_a_i != waddr_b_i || wdata_a_i != wdata_b_i))) begin
            m_mode = 1;
            if (m_err < 255) m_err++;
          end else if (we_a_i && we_b_i) begin
            if (waddr_a_i != 5'd0) m_sh[waddr_a_i] = wdata_a_i;
            m_spc = pc_i;
          end
        end
        1: begin
          if (halted_a_i && halted_b_i) begin
            xfer_t x;
            m_q.delete();
            for (int n = 1; n < 32; n++) begin
              x.a = GPR_BASE + 15'(4 * n);
              x.d = m_sh[n];
              m_q.push_back(x);
            end
            x.a = NPC_ADDR;
            x.d = m_spc;
            m_q.push_back(x);
            m_ga = 0; m_gb = 0;
            m_mode = 2;
          end
        end
        2: begin
          m_ga = m_ga | gnt_a_i;
          m_gb = m_gb | gnt_b_i;
          if (m_ga && m_gb) begin
            void'(m_q.pop_front());
            m_ga = 0; m_gb = 0;
            if (m_q.size() == 0) m_mode = 3;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      logic [14:0] ea;
      logic [31:0] ed;
      ea = (m_mode == 2) ? m_q[0].a : 15'h0;
      ed = (m_mode == 2) ? m_q[0].d : 32'h0;
      chk("halt_o",    32'(halt_o),      32'(m_mode == 1 || m_mode == 2));
      chk("resume_o",  32'(resume_o),    32'(m_mode == 3));
      chk("dbg_req_o", 32'(dbg_req_o),   32'(m_mode == 2));
      chk("dbg_we_o",  32'(dbg_we_o),    32'(m_mode == 2));
      chk("dbg_addr",  32'(dbg_addr_o),  32'(ea));
      chk("dbg_wdata", dbg_wdata_o,      ed);
      chk("busy_o",    32'(busy_o),      32'(m_mode != 0));
      chk("err_count", 32'(err_count_o), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  logic [14:0] lg_a [64];
  logic [31:0] lg_d [64];

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_halt"},   32'(halt_o),      32'd0);
    chk({nm, "_resume"}, 32'(resume_o),    32'd0);
    chk({nm, "_req"},    32'(dbg_req_o),   32'd0);
    chk({nm, "_we"},     32'(dbg_we_o),    32'd0);
    chk({nm, "_addr"},   32'(dbg_addr_o),  32'd0);
    chk({nm, "_wdata"},  dbg_wdata_o,      32'd0);
    chk({nm, "_busy"},   32'(busy_o),      32'd0);
    chk({nm, "_err"},    32'(err_count_o), 32'd0);
  endtask

  task automatic drive_wr(input logic wa, input logic wb, input logic [4:0] aa,
                          input logic [4:0] ab, input logic [31:0] da,
                          input logic [31:0] db, input logic [31:0] pc);
    we_a_i = wa; we_b_i = wb; waddr_a_i = aa; waddr_b_i = ab;
    wdata_a_i = da; wdata_b_i = db; pc_i = pc;
    step();
    we_a_i = 1'b0; we_b_i = 1'b0;
  endtask

  // Raise both halted inputs and grant every debug request until resume.
  // stagger>0 delays gnt_b on the first transfer by that many cycles.
  // A request to abort_addr asserts reset instead of granting.
  task automatic recover(input int stagger, input logic [14:0] abort_addr,
                         output int nxf, output bit aborted);
    int cyc = 0;
    int sub = 0;
    nxf = 0;
    aborted = 0;
    halted_a_i = 1'b1;
    halted_b_i = 1'b1;
    while (!resume_o && cyc < 400) begin
      gnt_a_i = 1'b0;
      gnt_b_i = 1'b0;
      if (dbg_req_o) begin
        if (dbg_addr_o == abort_addr) begin
          rst_ni = 1'b0;
          aborted = 1;
          halted_a_i = 1'b0;
          halted_b_i = 1'b0;
          return;
        end
        if (nxf == 0 && stagger > 0) begin
          chk("stagger_addr_held", 32'(dbg_addr_o), 32'h404);
          gnt_a_i = (sub == 0);
          gnt_b_i = (sub == stagger);
          sub++;
        end else begin
          if (nxf == 1 && stagger > 0) chk("stagger_next_addr", 32'(dbg_addr_o), 32'h408);
          gnt_a_i = 1'b1;
          gnt_b_i = 1'b1;
        end
        if (gnt_b_i && nxf < 64) begin
          lg_a[nxf] = dbg_addr_o;
          lg_d[nxf] = dbg_wdata_o;
          nxf++;
        end
      end
      step();
      cyc++;
    end
    gnt_a_i = 1'b0;
    gnt_b_i = 1'b0;
    chk("recover_resume_seen", 32'(resume_o), 32'd1);
    halted_a_i = 1'b0;
    halted_b_i = 1'b0;
    step();
    chk("resume_single_pulse", 32'(resume_o), 32'd0);
    chk("busy_after_resume", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int nx;
    bit ab;
    step();
    step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // agreed write x5
    drive_wr(1, 1, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100);
    chk("agree_halt", 32'(halt_o), 32'd0);
    chk("agree_err", 32'(err_count_o), 32'd0);
    step();

    // enable-only mismatch on x5: shadow keeps DEADBEEF
    drive_wr(1, 0, 5'd5, 5'd5, 32'h1, 32'h1, 32'h200);
    chk("en_mism_halt", 32'(halt_o), 32'd1);
    chk("en_mism_err", 32'(err_count_o), 32'd1);
    step();
    step();
    recover(0, 15'h7FFF, nx, ab);
    chk("rec1_count", 32'(nx), 32'd32);
    chk("rec1_first_addr", 32'(lg_a[0]), 32'h404);
    chk("rec1_x5_addr", 32'(lg_a[4]), 32'h414);
    chk("rec1_x5_data", lg_d[4], 32'hDEADBEEF);
    chk("rec1_x31_addr", 32'(lg_a[30]), 32'h47C);
    chk("rec1_npc_addr", 32'(lg_a[31]), 32'h2000);
    chk("rec1_npc_data", lg_d[31], 32'h100);

    // data mismatch on x7, then only one core halts for 50 cycles
    drive_wr(1, 1, 5'd7, 5'd7, 32'h1, 32'h2, 32'h300);
    chk("d_mism_halt", 32'(halt_o), 32'd1);
    chk("d_mism_err", 32'(err_count_o), 32'd2);
    halted_a_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        we_a_i = 1'b1;          // mismatch while busy: not counted
      end else if (i == 20) begin
        we_a_i = 1'b1; we_b_i = 1'b1; waddr_a_i = 5'd6; waddr_b_i = 5'd6;
        wdata_a_i = 32'h55; wdata_b_i = 32'h55;   // agreed write while busy: ignored
      end
      step();
      we_a_i = 1'b0; we_b_i = 1'b0;
      chk("halt_wait_req", 32'(dbg_req_o), 32'd0);
    end
    chk("halt_wait_err", 32'(err_count_o), 32'd2);
    recover(3, 15'h7FFF, nx, ab);
    chk("rec2_count", 32'(nx), 32'd32);
    chk("rec2_x5_data", lg_d[4], 32'hDEADBEEF);
    chk("rec2_x6_data", lg_d[5], 32'h0);
    chk("rec2_x7_data", lg_d[6], 32'h0);
    chk("rec2_npc_data", lg_d[31], 32'h100);

    // reset mid-WR_REG at idx 10
    drive_wr(0, 1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0);
    recover(0, 15'h428, nx, ab);
    chk("abort_hit", 32'(ab), 32'd1);
    chk("abort_done_before", 32'(nx), 32'd9);
    #1;
    check_all_zero("abort");
    step();
    rst_ni = 1'b1;
    step();
    chk("post_abort_err", 32'(err_count_o), 32'd0);

    // counter saturation
    for (int k = 0; k < 255; k++) begin
      drive_wr(1, 0, 5'd2, 5'd2, 32'h9, 32'h9, 32'h0);
      recover(0, 15'h7FFF, nx, ab);
      if (k == 0) begin
        chk("lost_x5_data", lg_d[4], 32'h0);
        chk("lost_npc_data", lg_d[31], 32'h80);
      end
    end
    chk("sat_err", 32'(err_count_o), 32'hFF);
    drive_wr(1, 1, 5'd3, 5'd3, 32'h4, 32'h5, 32'h0);
    chk("sat_err_hold", 32'(err_count_o), 32'hFF);
    recover(0, 15'h7FFF, nx, ab);
    chk("sat_err_final", 32'(err_count_o), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ft_recovery_sequencer.md
# ft_recovery_sequencer

Lockstep checker and rollback sequencer for the dual zeroriscy fault-tolerant core. It compares the register-file write ports of both cores every cycle and keeps a shadow register file plus a saved PC of the last agreed state. On any disagreement it halts both cores and rewrites all GPRs and the next PC through their debug ports. It then resumes them. It drives the shared debug-port inputs of both cores, muxed with SoC debug traffic at the core top level.

## Interface
Parameters:
- `DBG_GPR_BASE`, 15'h400: debug address of x0; GPR n is at `DBG_GPR_BASE + {n,2'b00}`.
- `DBG_NPC_ADDR`, 15'h2000: debug address of the next-PC register.
- `BOOT_ADDR`, 32'h0000_0080: reset value of the saved PC.
- `CNT_WIDTH`, 8: width of the error counter.

Ports (clock and reset first):
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `we_a_i` / `we_b_i`  in  1  regfile write enable, core 0 / core 1
- `waddr_a_i` / `waddr_b_i`  in  5  regfile write address
- `wdata_a_i` / `wdata_b_i`  in  32  regfile write data
- `pc_i`  in  32  core 0 instruction address
- `halted_a_i` / `halted_b_i`  in  1  debug_halted from each core
- `gnt_a_i` / `gnt_b_i`  in  1  debug_gnt from each core
- `halt_o`  out  1  debug halt request to both cores
- `resume_o`  out  1  debug resume request, one-cycle pulse
- `dbg_req_o`  out  1  debug access request to both cores
- `dbg_we_o`  out  1  debug write enable
- `dbg_addr_o`  out  15  debug address
- `dbg_wdata_o`  out  32  debug write data
- `busy_o`  out  1  high whenever the FSM is not in IDLE
- `err_count_o`  out  CNT_WIDTH  saturating count of detected mismatches

## Operation
- Mismatch is evaluated combinationally and only in IDLE. It is true when `we_a_i != we_b_i`, or when both enables are 1 and the addresses or data differ.
- Agreed write: both enables are 1 with equal address and data. At the next edge the block stores `shadow[waddr] <= wdata` (x0 is never stored and always reads 0) and `spc <= pc_i`. Agreed writes are ignored outside IDLE.
- FSM states: IDLE, HALT, WR_REG, WR_PC, RESUME.
  - IDLE: on mismatch go to HALT and increment `err_count`, saturating at all-ones.
  - HALT: `halt_o=1`. When `halted_a_i & halted_b_i` are both high, go to WR_REG with `idx=1`.
  - WR_REG: `dbg_req_o=1`, `dbg_we_o=1`, `dbg_addr_o=DBG_GPR_BASE+{idx,2'b00}`, `dbg_wdata_o=shadow[idx]`.
    - Sticky flags `ga`/`gb` are set by `gnt_a_i`/`gnt_b_i` while `dbg_req_o=1`.
    - When both are set (including both in the same cycle, or via the current-cycle grant), the flags clear and `idx` increments.
    - After `idx=31` completes, go to WR_PC.
  - WR_PC: same handshake with `dbg_addr_o=DBG_NPC_ADDR` and `dbg_wdata_o=spc`. On completion go to RESUME.
  - RESUME: `halt_o=0`, `resume_o=1` for exactly one cycle, `dbg_req_o=0`, then return to IDLE.
- `halt_o` stays high from HALT through WR_PC.
- Grants seen while `dbg_req_o=0` are ignored.
- A mismatch arriving while busy is neither counted nor queued.

## Timing
- All outputs are registered.
- Reset values:
  - every output is 0;
  - FSM is in IDLE, `idx=0`, grant flags are clear;
  - all shadow registers are 0;
  - `spc=BOOT_ADDR`.
- A mismatch sampled at edge N gives `halt_o=1` and `busy_o=1` from N+1. `err_count_o` updates at N+1.
- The first GPR request is asserted one cycle after the edge that samples both halted inputs high.
- Each debug transfer lasts at least one cycle. `dbg_req_o`, address and data are held stable until both grants have been seen. The next address is presented the cycle after the completing grant.
- Minimum recovery time with same-cycle grants: 1 (HALT) + 31 + 1 + 1 = 34 cycles after the halted inputs go high.
- Asserting reset mid-operation aborts immediately. Outputs and all state return to their reset values, and the shadow contents are lost.

## Test plan
- Matching write, both cores x5=32'hDEADBEEF, `pc_i`=32'h100 → no `halt_o`, `err_count_o`=0. A later forced recovery writes 32'hDEADBEEF at address 15'h414 and 32'h100 at 15'h2000.
- Data mismatch on x7 (1 vs 2) → `halt_o`=1 next cycle and `err_count_o`=1. After both halted inputs go high: 31 writes to 15'h404…15'h47C, then 15'h2000, then one `resume_o` pulse, then `busy_o`=0.
- Enable-only mismatch (`we_a_i`=1, `we_b_i`=0) → recovery starts. The shadow entry is unchanged.
- Staggered grants (`gnt_a_i` at cycle k, `gnt_b_i` at k+3) → request, address and data held through k+3. `idx` advances by exactly 1.
- Only `halted_a_i` high for 50 cycles → FSM stays in HALT with `dbg_req_o`=0. Recovery proceeds once `halted_b_i` rises.
- Reset asserted in WR_REG at `idx`=10 → all outputs 0 asynchronously. After release, 255 forced mismatches give `err_count_o`=8'hFF, and it stays 8'hFF afterwards.
